// File: rtl/ui_in_conditioner.sv
// Conditions asynchronous ui_in pins: SYNC_STAGES-deep synchroniser, per-bit debounce and rise/fall strobes.
// Define UI_IN_COND_GLITCH_CNT_EN to add a saturating 8-bit count of cycles that rejected a glitch.
module ui_in_conditioner #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] ui_in,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
`ifdef UI_IN_COND_GLITCH_CNT_EN
   ,
   output logic [7:0]       glitch_cnt
`endif
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  s;
   logic [WIDTH-1:0][CW-1:0]          cnt_q;
   logic [WIDTH-1:0][CW-1:0]          cnt_d;
   logic [WIDTH-1:0]                  ui_d;
`ifdef UI_IN_COND_GLITCH_CNT_EN
   logic                              glitch_hit;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= pin_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
   always_comb begin
      ui_d  = ui_in;
      cnt_d = cnt_q;
`ifdef UI_IN_COND_GLITCH_CNT_EN
      glitch_hit = 1'b0;
`endif
      for (int i = 0; i < WIDTH; i++) begin
         if (s[i] != ui_in[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ui_d[i]  = s[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else begin
            // A run that ended before reaching the threshold was a glitch.
`ifdef UI_IN_COND_GLITCH_CNT_EN
            if (cnt_q[i] != '0) glitch_hit = 1'b1;
`endif
            cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ui_in <= '0;
         rise  <= '0;
         fall  <= '0;
         cnt_q <= '0;
      end else begin
         ui_in <= ui_d;
         rise  <= ui_d & ~ui_in;
         fall  <= ~ui_d & ui_in;
         cnt_q <= cnt_d;
      end
   end

`ifdef UI_IN_COND_GLITCH_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         glitch_cnt <= '0;
      end else if (glitch_hit && glitch_cnt != 8'hFF) begin
         glitch_cnt <= glitch_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: doc/ui_in_conditioner.md
Name: ui_in_conditioner

Overview:
- Input-conditioning stage between the iCE40 ui_in package pins and the user design's ui_in bus.
- Synchronises each asynchronous pin into the clk domain with a flop chain.
- Debounces each bit with a per-bit consecutive-cycle counter.
- Emits single-cycle rise/fall strobes alongside the clean level.

Parameters:
- WIDTH, 8, number of conditioned input bits.
- SYNC_STAGES, 2, synchroniser flops per bit; legal range >=2.
- DEBOUNCE_CYCLES, 4, consecutive mismatching cycles required before the clean level flips; legal range >=1. Counter width CW = clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  global clock, from the global-buffer clock pin.
- rst  input  1  synchronous active-high reset.
- pin_in  input  WIDTH  raw asynchronous pin levels.
- ui_in  output  WIDTH  debounced, synchronised level for the user design.
- rise  output  WIDTH  one-cycle strobe; bit went 0->1 on ui_in this cycle.
- fall  output  WIDTH  one-cycle strobe; bit went 1->0 on ui_in this cycle.

Behaviour:
- Reset, sampled on the clk edge: all sync flops, ui_in, rise, fall and per-bit counters go to 0. Reset mid-debounce discards partial counts. Reset dominates all other activity in the same cycle.
- Synchroniser: s[i] is the last flop of a SYNC_STAGES chain clocked from pin_in[i]. No logic between chain flops.
- Per-bit debounce, evaluated every edge when rst=0:
  - s[i]!=ui_in[i] and cnt[i]==DEBOUNCE_CYCLES-1: ui_in[i] <= s[i], cnt[i] <= 0.
  - s[i]!=ui_in[i] otherwise: cnt[i] <= cnt[i]+1.
  - s[i]==ui_in[i]: cnt[i] <= 0. Any partial run is a rejected glitch.
- Strobes are registered and asserted in the same cycle as the ui_in change:
  - rise[i]=1 exactly when ui_in[i] goes 0->1.
  - fall[i]=1 exactly when ui_in[i] goes 1->0.
  - Never both at once; never longer than 1 cycle.
- Latency: the pin changes and is held; edge E0 is the first edge that captures the new value. s flips at E0+SYNC_STAGES-1 and ui_in flips at E0+SYNC_STAGES-1+DEBOUNCE_CYCLES. With the defaults ui_in flips at E0+5.
- DEBOUNCE_CYCLES=1: no filtering; ui_in follows s with 1 cycle delay.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- A mismatch run that ends one cycle short of threshold is rejected; ui_in is unchanged.
- Bits are fully independent; simultaneous changes on several bits produce simultaneous strobes.
- Pin held high through reset release: ui_in rises and rise pulses after the normal latency. This is required behaviour, not suppressed.

Optional Feature:
- Macro: UI_IN_COND_GLITCH_CNT_EN.
- When defined:
  - Adds output glitch_cnt (8 bits).
  - Reset value 0.
  - Increments by 1 on each edge where at least one bit takes the "s==ui_in and cnt!=0" path.
  - Saturates at 255.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold pin_in=8'hFF with rst=1 for 3 cycles, then release -> ui_in=0, rise=0, fall=0 during reset. ui_in becomes 8'hFF at edge 6 after release, with rise=8'hFF for exactly that cycle.
- Clean step: pin_in[3] 0->1 captured at E0 -> ui_in[3]=1 and rise[3]=1 at E0+5. rise[3]=0 at E0+6. Other bits unchanged.
- Glitch rejection: pin_in[0] high for exactly 3 cycles, then low -> ui_in[0] stays 0, no strobes. With the macro defined, glitch_cnt=1.
- Threshold: pin_in[0] high for exactly 4 cycles -> ui_in[0] rises at E0+5 with rise[0]. It falls 4 cycles after the low level reaches s, with fall[0].
- Multi-bit and reset mid-run: pin_in 8'h00->8'hA5 -> ui_in=8'hA5 and rise=8'hA5 in one cycle. Repeat, asserting rst at E0+3 -> ui_in stays 0 and counters clear.
- Saturation (macro defined): apply 300 three-cycle glitches on bit 1 -> glitch_cnt=255 and ui_in[1]=0 throughout.
